// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state encoding and bus widths for the Wishbone master port.
package wb_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    localparam int SEL_W = 2;
    localparam int ADR_W = 32;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: counts unacknowledged BUS cycles; expired marks the last one allowed.
// Only built when WB_MASTER_TIMEOUT_EN is defined.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_timeout_ctr #(
    parameter int timeout = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(timeout + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d     = clear_i ? '0 : enable_i ? cnt_q + 1'b1 : cnt_q;
    assign expired_o = cnt_q == CNT_W'(timeout - 1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule
`endif

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone classic-cycle initiator.
// Define WB_MASTER_TIMEOUT_EN to add the no-ack bus watchdog (wb_timeout_ctr).
module wb_master_port
    import wb_master_pkg::*;
#(
    parameter int data_width = 32,
    parameter int timeout    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADR_W-1:0]      req_adr_i,
    input  logic [data_width-1:0] req_dat_i,
    input  logic [SEL_W-1:0]      req_sel_i,
    output logic                  rsp_valid_o,
    output logic [data_width-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic [ADR_W-1:0]      wbm_adr_o,
    output logic [data_width-1:0] wbm_dat_o,
    input  logic [data_width-1:0] wbm_dat_i,
    output logic [SEL_W-1:0]      wbm_sel_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    input  logic                  wbm_ack_i
);

    state_e                state_q, state_d;
    logic [ADR_W-1:0]      adr_q, adr_d;
    logic [data_width-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  we_q, we_d, cyc_q, cyc_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                  accept, expired;

    // A watchdog of zero cycles could never let a slave answer.
    if (timeout < 1) begin : g_bad_timeout
    end

    assign req_ready_o = state_q == IDLE;
    assign accept      = req_valid_i && req_ready_o;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_ctr #(.timeout(timeout)) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (accept),
        .enable_i  (state_q == BUS && !wbm_ack_i),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        if (state_q == IDLE) begin
            cyc_d = accept;
            if (accept) begin
                state_d = BUS;
                adr_d   = req_adr_i;
                dat_d   = req_dat_i;
                sel_d   = req_sel_i;
                we_d    = req_we_i;
            end
        end else if (wbm_ack_i || expired) begin
            // ack beats a simultaneous watchdog expiry
            state_d     = IDLE;
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !wbm_ack_i;
            if (wbm_ack_i && !we_q) rsp_dat_d = wbm_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = we_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule
